// File: rtl/audio_dac_player.sv
`default_nettype none
// ============================================================================
//  Module      : audio_dac_player
//  Description : Buffers 32-bit stereo samples from the mixer in a small FIFO
//                and shifts them out to the codec DAC in I2S format, 16 bits
//                per channel, slaved to codec-supplied BCLK and DACLRCK.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_dac_player #(
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [31:0]      i_data,
    output logic             o_ready,
    input  logic             i_bclk,
    input  logic             i_daclrck,
    output logic             o_dacdat,
    output logic             o_underflow,
    output logic [LVL_W-1:0] o_level
);

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LEFT = 2'd1,
        ST_STREAM    = 2'd2
    } state_t;

    state_t           state_q;
    logic [1:0]       bclk_sync_q;
    logic [1:0]       lrck_sync_q;
    logic             bclk_prev_q;
    logic             lr_cur_q;
    logic             lr_prev_q;
    logic [4:0]       bitcnt_q;     // bit 4 set means no bits left in this half
    logic [31:0]      frame_q;
    logic [31:0]      frame_d;
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             dacdat_q;
    logic             underflow_q;

    logic             bclk_rise;
    logic             bclk_fall;
    logic             msb_slot;
    logic             enabled;
    logic             left_load;
    logic             fifo_empty;
    logic             do_push;
    logic             do_pop;
    logic [4:0]       bit_idx;
    logic             slot_live;
    logic             streaming;

    // Slot decode: the MSB slot is the first fall after an LR change; left
    // channel reads frame[31:16], right reads frame[15:0].
    assign bclk_rise  = bclk_sync_q[1] & ~bclk_prev_q;
    assign bclk_fall  = ~bclk_sync_q[1] & bclk_prev_q;
    assign msb_slot   = (lr_cur_q != lr_prev_q);
    assign enabled    = i_en & (state_q != ST_IDLE);
    assign left_load  = bclk_fall & msb_slot & ~lr_cur_q & enabled;
    assign fifo_empty = (level_q == '0);
    assign do_push    = i_valid & o_ready;
    assign do_pop     = left_load & ~fifo_empty;
    assign o_ready    = enabled & (level_q != FULL_LVL);
    assign frame_d    = left_load ? (fifo_empty ? 32'd0 : mem_q[rd_ptr_q]) : frame_q;
    assign bit_idx    = {~lr_cur_q, (msb_slot ? 4'd15 : bitcnt_q[3:0])};
    assign slot_live  = msb_slot | ~bitcnt_q[4];
    assign streaming  = (state_q == ST_STREAM) | left_load;

    assign o_dacdat    = dacdat_q;
    assign o_underflow = underflow_q;
    assign o_level     = level_q;

    // Two-flop synchronisers for the codec clocks plus a BCLK history flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bclk_sync_q <= 2'b00;
            lrck_sync_q <= 2'b00;
            bclk_prev_q <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[0], i_bclk};
            lrck_sync_q <= {lrck_sync_q[0], i_daclrck};
            bclk_prev_q <= bclk_sync_q[1];
        end
    end

    // LR history sampled on BCLK rises; bit counter advanced on BCLK falls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lr_cur_q  <= 1'b0;
            lr_prev_q <= 1'b0;
            bitcnt_q  <= 5'h1F;
        end else begin
            if (bclk_rise) begin
                lr_prev_q <= lr_cur_q;
                lr_cur_q  <= lrck_sync_q[1];
            end
            if (bclk_fall) begin
                if (msb_slot) begin
                    bitcnt_q <= 5'd14;
                end else if (!bitcnt_q[4]) begin
                    bitcnt_q <= bitcnt_q - 5'd1;
                end
            end
        end
    end

    // FIFO pointers and occupancy; disabling playback flushes the queue.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (!i_en) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_data;
    end

    // Channel-tracking FSM with frame register and registered serial output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            frame_q     <= 32'd0;
            dacdat_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= 1'b0;
            if (!i_en) begin
                state_q  <= ST_IDLE;
                frame_q  <= 32'd0;
                dacdat_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE:      state_q <= ST_WAIT_LEFT;
                    ST_WAIT_LEFT: if (left_load) state_q <= ST_STREAM;
                    ST_STREAM:    state_q <= ST_STREAM;
                    default:      state_q <= ST_IDLE;
                endcase
                frame_q <= frame_d;
                if (left_load && fifo_empty) underflow_q <= 1'b1;
                if (bclk_fall) dacdat_q <= streaming & slot_live & frame_d[bit_idx];
            end
        end
    end

endmodule
`default_nettype wire
